decode_stage: RTL and testbench

Parametrised, registered RV32I instruction decode stage. Sits between fetch and execute, with a valid/ready handshake on both sides. Generalises the combinational decoder in four ways:
- XLEN-wide immediates.
- A 4-bit ALU control that distinguishes SLT from SLTU and adds a pass-through op for LUI.
- Branch/jump/illegal flags.
- One pipeline register with stall, flush and a saturating illegal-instruction counter.

---
 rtl/decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered RV32I instruction decode stage with valid/ready
//                handshakes to fetch and execute, flush, and a saturating
//                count of accepted illegal instructions.
//  Ports       : clk, rst (sync, active-high), flush
//                fetch side   : in_valid, in_ready, inst[31:0], pc[XLEN-1:0]
//                execute side : out_valid, out_ready, out_pc, rd, rs1, rs2,
//                               funct3, reg_write, mem_read, mem_write,
//                               alu_src, branch, jump, alu_ctrl, imm,
//                               illegal, illegal_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int ALU_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src,
    output logic             branch,
    output logic             jump,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]  imm,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;

    localparam logic [ALU_W-1:0] c_alu_add   = ALU_W'(0);
    localparam logic [ALU_W-1:0] c_alu_sub   = ALU_W'(1);
    localparam logic [ALU_W-1:0] c_alu_sll   = ALU_W'(2);
    localparam logic [ALU_W-1:0] c_alu_slt   = ALU_W'(3);
    localparam logic [ALU_W-1:0] c_alu_sltu  = ALU_W'(4);
    localparam logic [ALU_W-1:0] c_alu_xor   = ALU_W'(5);
    localparam logic [ALU_W-1:0] c_alu_srl   = ALU_W'(6);
    localparam logic [ALU_W-1:0] c_alu_sra   = ALU_W'(7);
    localparam logic [ALU_W-1:0] c_alu_or    = ALU_W'(8);
    localparam logic [ALU_W-1:0] c_alu_and   = ALU_W'(9);
    localparam logic [ALU_W-1:0] c_alu_passb = ALU_W'(10);

    localparam logic [6:0]       c_f7_zero = 7'b0000000;
    localparam logic [6:0]       c_f7_alt  = 7'b0100000;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]       w_opcode;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic [4:0]       w_rd;
    logic             w_rw_raw, w_mr_raw, w_mw_raw, w_br_raw, w_jp_raw;
    logic             w_alu_src;
    logic             w_ill;
    logic [ALU_W-1:0] w_alu_raw;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic             w_rw, w_mr, w_mw, w_br, w_jp;
    logic [ALU_W-1:0] w_alu;

    assign w_opcode = inst[6:0];
    assign w_rd     = inst[11:7];
    assign w_f3     = inst[14:12];
    assign w_f7     = inst[31:25];

    always_comb begin
        w_rw_raw  = 1'b0;
        w_mr_raw  = 1'b0;
        w_mw_raw  = 1'b0;
        w_br_raw  = 1'b0;
        w_jp_raw  = 1'b0;
        w_alu_src = 1'b0;
        w_ill     = 1'b0;
        w_alu_raw = c_alu_add;
        w_imm32   = 32'd0;
        case (w_opcode)
            c_op_lui: begin
                w_rw_raw  = 1'b1;
                w_alu_src = 1'b1;
                w_alu_raw = c_alu_passb;
                w_imm32   = {inst[31:12], 12'b0};
            end
            c_op_auipc: begin
                w_rw_raw  = 1'b1;
                w_alu_src = 1'b1;
                w_imm32   = {inst[31:12], 12'b0};
            end
            c_op_jal: begin
                w_rw_raw = 1'b1;
                w_jp_raw = 1'b1;
                w_imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            end
            c_op_jalr: begin
                w_rw_raw  = 1'b1;
                w_jp_raw  = 1'b1;
                w_alu_src = 1'b1;
                w_imm32   = {{20{inst[31]}}, inst[31:20]};
                w_ill     = (w_f3 != 3'b000);
            end
            c_op_branch: begin
                w_br_raw = 1'b1;
                w_imm32  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
                // Unsigned compares need SLTU; equality and signed use SUB.
                case (w_f3)
                    3'b110, 3'b111: w_alu_raw = c_alu_sltu;
                    3'b010, 3'b011: w_ill     = 1'b1;
                    default:        w_alu_raw = c_alu_sub;
                endcase
            end
            c_op_load: begin
                w_rw_raw  = 1'b1;
                w_mr_raw  = 1'b1;
                w_alu_src = 1'b1;
                w_imm32   = {{20{inst[31]}}, inst[31:20]};
                w_ill     = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            c_op_store: begin
                w_mw_raw  = 1'b1;
                w_alu_src = 1'b1;
                w_imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                w_ill     = (w_f3 > 3'b010);
            end
            c_op_opimm: begin
                w_rw_raw  = 1'b1;
                w_alu_src = 1'b1;
                w_imm32   = {{20{inst[31]}}, inst[31:20]};
                case (w_f3)
                    3'b000: w_alu_raw = c_alu_add;
                    3'b010: w_alu_raw = c_alu_slt;
                    3'b011: w_alu_raw = c_alu_sltu;
                    3'b100: w_alu_raw = c_alu_xor;
                    3'b110: w_alu_raw = c_alu_or;
                    3'b111: w_alu_raw = c_alu_and;
                    3'b001: begin
                        w_imm32   = {27'd0, inst[24:20]};
                        w_alu_raw = c_alu_sll;
                        w_ill     = (w_f7 != c_f7_zero);
                    end
                    default: begin
                        w_imm32 = {27'd0, inst[24:20]};
                        if (w_f7 == c_f7_zero)
                            w_alu_raw = c_alu_srl;
                        else if (w_f7 == c_f7_alt)
                            w_alu_raw = c_alu_sra;
                        else
                            w_ill = 1'b1;
                    end
                endcase
            end
            c_op_op: begin
                w_rw_raw = 1'b1;
                if (w_f7 == c_f7_zero) begin
                    case (w_f3)
                        3'b000:  w_alu_raw = c_alu_add;
                        3'b001:  w_alu_raw = c_alu_sll;
                        3'b010:  w_alu_raw = c_alu_slt;
                        3'b011:  w_alu_raw = c_alu_sltu;
                        3'b100:  w_alu_raw = c_alu_xor;
                        3'b101:  w_alu_raw = c_alu_srl;
                        3'b110:  w_alu_raw = c_alu_or;
                        default: w_alu_raw = c_alu_and;
                    endcase
                end else if (w_f7 == c_f7_alt && w_f3 == 3'b000) begin
                    w_alu_raw = c_alu_sub;
                end else if (w_f7 == c_f7_alt && w_f3 == 3'b101) begin
                    w_alu_raw = c_alu_sra;
                end else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Illegal encodings suppress every side-effecting control.
    assign w_rw  = w_rw_raw && !w_ill && (w_rd != 5'd0);
    assign w_mr  = w_mr_raw && !w_ill;
    assign w_mw  = w_mw_raw && !w_ill;
    assign w_br  = w_br_raw && !w_ill;
    assign w_jp  = w_jp_raw && !w_ill;
    assign w_alu = w_ill ? c_alu_add : w_alu_raw;

    // Immediates are built at 32 bits then sign-extended to XLEN.
    generate
        if (XLEN > 32) begin : g_imm_wide
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_narrow
            assign w_imm = w_imm32[XLEN-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline register and handshake
    // ------------------------------------------------------------------
    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [4:0]       r_rd, r_rs1, r_rs2;
    logic [2:0]       r_f3;
    logic             r_rw, r_mr, r_mw, r_alu_src, r_br, r_jp, r_ill;
    logic [ALU_W-1:0] r_alu;
    logic [XLEN-1:0]  r_imm;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    // Flush blocks acceptance so the flushed cycle never loads new data.
    assign in_ready = (!r_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_f3      <= '0;
            r_rw      <= 1'b0;
            r_mr      <= 1'b0;
            r_mw      <= 1'b0;
            r_alu_src <= 1'b0;
            r_br      <= 1'b0;
            r_jp      <= 1'b0;
            r_ill     <= 1'b0;
            r_alu     <= '0;
            r_imm     <= '0;
            r_cnt     <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_pc      <= pc;
                r_rd      <= w_rd;
                r_rs1     <= inst[19:15];
                r_rs2     <= inst[24:20];
                r_f3      <= w_f3;
                r_rw      <= w_rw;
                r_mr      <= w_mr;
                r_mw      <= w_mw;
                r_alu_src <= w_alu_src;
                r_br      <= w_br;
                r_jp      <= w_jp;
                r_ill     <= w_ill;
                r_alu     <= w_alu;
                r_imm     <= w_imm;
            end else if (out_ready) begin
                // Reached only with no incoming instruction: plain drain.
                r_valid <= 1'b0;
            end
            if (w_accept && w_ill && (r_cnt != c_cnt_max))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign rd          = r_rd;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign funct3      = r_f3;
    assign reg_write   = r_rw;
    assign mem_read    = r_mr;
    assign mem_write   = r_mw;
    assign alu_src     = r_alu_src;
    assign branch      = r_br;
    assign jump        = r_jp;
    assign alu_ctrl    = r_alu;
    assign imm         = r_imm;
    assign illegal     = r_ill;
    assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage; a 32-bit
//                instance covers handshake, decode and counter behaviour,
//                a 64-bit instance covers wide immediate/pc handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] inst, pc;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        reg_write, mem_read, mem_write, alu_src, branch, jump, illegal;
    logic [3:0]  alu_ctrl;
    logic [7:0]  illegal_cnt;

    logic        b_in_valid;
    logic [31:0] b_inst;
    logic [63:0] b_pc;
    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_pc, b_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3;
    logic        b_reg_write, b_mem_read, b_mem_write, b_alu_src, b_branch, b_jump, b_illegal;
    logic [3:0]  b_alu_ctrl;
    logic [7:0]  b_illegal_cnt;

    decode_stage #(.XLEN(32), .ALU_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .branch(branch), .jump(jump), .alu_ctrl(alu_ctrl),
        .imm(imm), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    decode_stage #(.XLEN(64), .ALU_W(4), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .inst(b_inst), .pc(b_pc), .out_valid(b_out_valid), .out_ready(1'b1),
        .out_pc(b_out_pc), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .funct3(b_funct3),
        .reg_write(b_reg_write), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .alu_src(b_alu_src), .branch(b_branch), .jump(b_jump), .alu_ctrl(b_alu_ctrl),
        .imm(b_imm), .illegal(b_illegal), .illegal_cnt(b_illegal_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = 32'd0; pc = 32'd0;
        b_in_valid = 1'b0; b_inst = 32'd0; b_pc = 64'd0;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cnt", 64'(illegal_cnt), 64'd0);
        chk("rst_imm", 64'(imm), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // addi x1,x2,-5
        inst = 32'hFFB10093; pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_rd", 64'(rd), 64'd1);
        chk("addi_rs1", 64'(rs1), 64'd2);
        chk("addi_imm", 64'(imm), 64'hFFFFFFFB);
        chk("addi_alu", 64'(alu_ctrl), 64'd0);
        chk("addi_alu_src", 64'(alu_src), 64'd1);
        chk("addi_rw", 64'(reg_write), 64'd1);
        chk("addi_pc", 64'(out_pc), 64'h100);
        chk("addi_illegal", 64'(illegal), 64'd0);

        // 64-bit instance: beq x0,x0,-4
        b_inst = 32'hFE000EE3; b_pc = 64'h1_0000_0010; b_in_valid = 1'b1;
        // sub x3,x1,x2 on the 32-bit instance in the same cycle
        inst = 32'h402081B3; pc = 32'h104;
        tick();
        b_in_valid = 1'b0;
        chk("beq64_imm", b_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("beq64_branch", 64'(b_branch), 64'd1);
        chk("beq64_alu", 64'(b_alu_ctrl), 64'd1);
        chk("beq64_pc", b_out_pc, 64'h1_0000_0010);
        chk("beq64_rw", 64'(b_reg_write), 64'd0);
        chk("sub_alu", 64'(alu_ctrl), 64'd1);
        chk("sub_alu_src", 64'(alu_src), 64'd0);
        chk("sub_rd", 64'(rd), 64'd3);
        chk("sub_rs2", 64'(rs2), 64'd2);

        // Stall three cycles with LUI waiting at the input
        inst = 32'h123452B7; pc = 32'h108; out_ready = 1'b0;
        #1;
        chk("stall_in_ready0", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_alu", 64'(alu_ctrl), 64'd1);
            chk("stall_pc", 64'(out_pc), 64'h104);
            chk("stall_rd", 64'(rd), 64'd3);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("lui_imm", 64'(imm), 64'h12345000);
        chk("lui_alu", 64'(alu_ctrl), 64'd10);
        chk("lui_rd", 64'(rd), 64'd5);
        chk("lui_rw", 64'(reg_write), 64'd1);
        chk("lui_pc", 64'(out_pc), 64'h108);

        // sltiu x0,x1,1 back-to-back
        inst = 32'h0010B013; pc = 32'h10C;
        tick();
        chk("sltiu_valid", 64'(out_valid), 64'd1);
        chk("sltiu_rw", 64'(reg_write), 64'd0);
        chk("sltiu_alu", 64'(alu_ctrl), 64'd4);
        chk("sltiu_imm", 64'(imm), 64'd1);

        // Flush with in_valid and out_ready high
        inst = 32'hFFB10093; pc = 32'h200; flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_not_loaded", 64'(out_pc), 64'h10C);

        // bltu x0,x0,-4 then drain
        inst = 32'hFE006EE3; pc = 32'h300;
        tick();
        chk("bltu_alu", 64'(alu_ctrl), 64'd4);
        chk("bltu_branch", 64'(branch), 64'd1);
        chk("bltu_imm", 64'(imm), 64'hFFFFFFFC);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Illegal LOAD funct3=011
        inst = 32'h00003083; pc = 32'h400; in_valid = 1'b1;
        tick();
        chk("ld_ill", 64'(illegal), 64'd1);
        chk("ld_ill_mr", 64'(mem_read), 64'd0);
        chk("ld_ill_rw", 64'(reg_write), 64'd0);
        chk("ld_ill_cnt", 64'(illegal_cnt), 64'd1);
        exp_cnt = 1;

        // All-zero word 260 times: counter saturates at 255
        inst = 32'h00000000;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (exp_cnt < 255) exp_cnt++;
            chk("zero_ill", 64'(illegal), 64'd1);
            chk("zero_ctrl", 64'({reg_write, mem_read, mem_write, branch, jump, alu_src}), 64'd0);
            chk("zero_alu", 64'(alu_ctrl), 64'd0);
            chk("zero_cnt", 64'(illegal_cnt), 64'(exp_cnt));
        end
        chk("cnt_final", 64'(illegal_cnt), 64'd255);

        // Flush leaves the counter alone
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_cnt", 64'(illegal_cnt), 64'd255);
        chk("flush2_valid", 64'(out_valid), 64'd0);

        // Reset during a stall drops the held instruction
        inst = 32'h402081B3; pc = 32'h500;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        tick();
        chk("prestall_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_stall_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_cnt", 64'(illegal_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
